// File: rtl/rx_pkg.sv
// Shared RX recovery definitions: buffer geometry, sync header codes, lock states.
package rx_pkg;

  localparam int unsigned BUF_W    = 194;
  localparam int unsigned BLOCK_W  = 66;
  localparam int unsigned OFFSET_W = 7;
  localparam int unsigned DATA_W   = 64;

  localparam logic [1:0] HDR_DATA   = 2'b01;
  localparam logic [1:0] HDR_CTRL   = 2'b10;
  localparam logic [5:0] GBOX_PAUSE = 6'd32;

  typedef enum logic {HUNT, LOCKED} lock_state_t;

  // A sync header is good only when its two bits differ.
  function automatic logic hdr_is_good(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/hdr_lock_fsm.sv
// Header-lock state machine: counts good headers in HUNT, monitors header
// errors per window in LOCKED, and signals re-alignment when errors pile up.
module hdr_lock_fsm
  import rx_pkg::*;
#(
  parameter int unsigned GOOD_CNT = 64,
  parameter int unsigned WINDOW   = 1024,
  parameter int unsigned BAD_MAX  = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic valid_i,
  input  logic hdr_ok_i,
  input  logic offset_changed_i,
  output logic locked_o,
  output logic relock_o
);

  localparam int unsigned GW = $clog2(GOOD_CNT + 1);
  localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned BW = $clog2(BAD_MAX + 1);

  lock_state_t   state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          relock_q, relock_d;

  logic [GW-1:0] good_base;
  logic [BW-1:0] bad_base;
  logic          win_wrap;

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= HUNT;
      good_q   <= '0;
      win_q    <= '0;
      bad_q    <= '0;
      relock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      win_q    <= win_d;
      bad_q    <= bad_d;
      relock_q <= relock_d;
    end
  end

  // Next-state and counter updates, applied only on valid blocks.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    win_d     = win_q;
    bad_d     = bad_q;
    relock_d  = 1'b0;
    good_base = offset_changed_i ? '0 : good_q;
    win_wrap  = (win_q == WW'(WINDOW - 1));
    bad_base  = win_wrap ? '0 : bad_q;
    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          // An offset change restarts the count, but this block's header still counts.
          good_d = hdr_ok_i ? good_base + GW'(1) : '0;
          if (hdr_ok_i && (good_base + GW'(1) == GW'(GOOD_CNT))) begin
            state_d = LOCKED;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
          end
        end
        LOCKED: begin
          if (offset_changed_i) begin
            state_d = HUNT;
            good_d  = hdr_ok_i ? GW'(1) : '0;
          end else begin
            win_d = win_wrap ? '0 : win_q + WW'(1);
            bad_d = bad_base + BW'(!hdr_ok_i);
            if (bad_base + BW'(!hdr_ok_i) == BW'(BAD_MAX)) begin
              state_d  = HUNT;
              relock_d = 1'b1;
              good_d   = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Outputs derived from registered state.
  always_comb begin
    locked_o = (state_q == LOCKED);
    relock_o = relock_q;
  end

endmodule

// File: rtl/block_extract66.sv
// Slices one 66-bit block per valid gearbox buffer, splits header/payload,
// checks the header and drives the header-lock state machine.
module block_extract66
  import rx_pkg::*;
#(
  parameter int unsigned GOOD_CNT = 64,
  parameter int unsigned WINDOW   = 1024,
  parameter int unsigned BAD_MAX  = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         buffer_dv_i,
  input  logic [193:0] gbox_buffer_i,
  input  logic [5:0]   gbox_cnt_i,
  input  logic [6:0]   block_offset_i,
  output logic [63:0]  data_o,
  output logic [1:0]   header_o,
  output logic         data_dv_o,
  output logic         hdr_err_o,
  output logic         locked_o,
  output logic         relock_o
);

  logic [BLOCK_W-1:0]  slice;
  logic [7:0]          slice_lsb;
  logic                blk_valid;
  logic                hdr_ok;
  logic                offset_changed;

  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          hdr_q, hdr_d;
  logic                dv_q, dv_d;
  logic                err_q, err_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;

  // Block selection and per-block strobes.
  always_comb begin
    slice_lsb      = 8'(block_offset_i);
    slice          = gbox_buffer_i[slice_lsb +: BLOCK_W];
    blk_valid      = buffer_dv_i && (gbox_cnt_i != GBOX_PAUSE);
    hdr_ok         = hdr_is_good(slice[BLOCK_W-1 -: 2]);
    offset_changed = (block_offset_i != offset_q);
  end

  // Output and offset-latch next values; payload/header hold between blocks.
  always_comb begin
    data_d   = data_q;
    hdr_d    = hdr_q;
    offset_d = offset_q;
    dv_d     = blk_valid;
    err_d    = blk_valid && !hdr_ok;
    if (blk_valid) begin
      data_d   = slice[DATA_W-1:0];
      hdr_d    = slice[BLOCK_W-1 -: 2];
      offset_d = block_offset_i;
    end
  end

  // Output registers and offset latch.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q   <= '0;
      hdr_q    <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      offset_q <= '0;
    end else begin
      data_q   <= data_d;
      hdr_q    <= hdr_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      offset_q <= offset_d;
    end
  end

  hdr_lock_fsm #(
    .GOOD_CNT (GOOD_CNT),
    .WINDOW   (WINDOW),
    .BAD_MAX  (BAD_MAX)
  ) u_hdr_lock_fsm (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .valid_i          (blk_valid),
    .hdr_ok_i         (hdr_ok),
    .offset_changed_i (offset_changed),
    .locked_o         (locked_o),
    .relock_o         (relock_o)
  );

  assign data_o    = data_q;
  assign header_o  = hdr_q;
  assign data_dv_o = dv_q;
  assign hdr_err_o = err_q;

endmodule

// File: tb/tb_block_extract66.sv
// Self-checking bench for block_extract66: behavioural model plus directed pins.
module tb_block_extract66;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         buffer_dv;
  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic [6:0]   block_offset;
  logic [63:0]  data;
  logic [1:0]   header;
  logic         data_dv, hdr_err, locked, relock;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  block_extract66 #(
    .GOOD_CNT (64),
    .WINDOW   (1024),
    .BAD_MAX  (16)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .buffer_dv_i    (buffer_dv),
    .gbox_buffer_i  (gbox_buffer),
    .gbox_cnt_i     (gbox_cnt),
    .block_offset_i (block_offset),
    .data_o         (data),
    .header_o       (header),
    .data_dv_o      (data_dv),
    .hdr_err_o      (hdr_err),
    .locked_o       (locked),
    .relock_o       (relock)
  );

  // Model state: plain counts of blocks, windows and headers.
  logic [63:0] e_data = '0;
  logic [1:0]  e_hdr = '0;
  bit          e_dv = 0, e_err = 0, e_locked = 0, e_relock = 0;
  int          m_good = 0, m_blocks = 0, m_win = 0, m_bad = 0;
  int          m_last_off = 0;

  always @(posedge clk) begin
    logic [65:0] sl;
    bit ok;
    e_dv = 0; e_err = 0; e_relock = 0;
    if (!rst_n) begin
      e_data = '0; e_hdr = '0; e_locked = 0;
      m_good = 0; m_blocks = 0; m_win = 0; m_bad = 0; m_last_off = 0;
    end else if (buffer_dv && gbox_cnt != 6'd32) begin
      sl = gbox_buffer[int'(block_offset) +: 66];
      e_data = sl[63:0];
      e_hdr  = sl[65:64];
      ok     = (e_hdr == 2'b01) || (e_hdr == 2'b10);
      e_dv   = 1;
      e_err  = !ok;
      if (e_locked) begin
        if (int'(block_offset) != m_last_off) begin
          e_locked = 0;
          m_good = ok ? 1 : 0;
        end else begin
          m_blocks++;
          if (m_blocks / 1024 != m_win) begin
            m_win = m_blocks / 1024;
            m_bad = 0;
          end
          if (!ok) m_bad++;
          if (m_bad == 16) begin
            e_locked = 0; e_relock = 1; m_good = 0;
          end
        end
      end else begin
        if (int'(block_offset) != m_last_off) m_good = 0;
        m_good = ok ? m_good + 1 : 0;
        if (m_good == 64) begin
          e_locked = 1; m_good = 0; m_blocks = 0; m_win = 0; m_bad = 0;
        end
      end
      m_last_off = int'(block_offset);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("data_dv", 64'(data_dv), 64'(e_dv));
    chk("hdr_err", 64'(hdr_err), 64'(e_err));
    chk("locked",  64'(locked),  64'(e_locked));
    chk("relock",  64'(relock),  64'(e_relock));
    chk("data",    data,         e_data);
    chk("header",  64'(header),  64'(e_hdr));
  end

  function automatic logic [193:0] rand_buf();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[193:0];
  endfunction

  task automatic step(input bit r, input bit dv, input logic [5:0] cnt,
                      input logic [6:0] off, input logic [193:0] b);
    rst_n = r; buffer_dv = dv; gbox_cnt = cnt; block_offset = off; gbox_buffer = b;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [6:0] off, input logic [1:0] hdr, input logic [63:0] d);
    logic [193:0] b;
    b = rand_buf();
    b[int'(off) +: 66] = {hdr, d};
    step(1, 1, 6'($urandom_range(0, 31)), off, b);
  endtask

  task automatic good(input logic [6:0] off);
    send(off, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, {$urandom, $urandom});
  endtask

  task automatic bad(input logic [6:0] off);
    send(off, ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, {$urandom, $urandom});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 6'd0, 7'd0, rand_buf());
  endtask

  initial begin
    rst_n = 0; buffer_dv = 0; gbox_cnt = '0; block_offset = '0; gbox_buffer = '0;

    // Reset held with buffers offered.
    for (int i = 0; i < 3; i++) step(0, 1, 6'd3, 7'd5, rand_buf());
    chk("rst_dv", 64'(data_dv), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_data", data, 64'd0);
    idle(1);
    chk("post_rst_dv", 64'(data_dv), 64'd0);

    // Slice at offset 5.
    send(7'd5, 2'b10, 64'hDEADBEEF_01234567);
    chk("slice_dv", 64'(data_dv), 64'd1);
    chk("slice_hdr", 64'(header), 64'h2);
    chk("slice_data", data, 64'hDEADBEEF_01234567);
    chk("slice_err", 64'(hdr_err), 64'd0);
    idle(1);
    chk("hold_dv", 64'(data_dv), 64'd0);
    chk("hold_data", data, 64'hDEADBEEF_01234567);

    // Lock at offset 40, sparse blocks; bad 63rd restarts the count.
    for (int i = 0; i < 62; i++) begin good(7'd40); idle(7); end
    bad(7'd40);
    chk("bad63_err", 64'(hdr_err), 64'd1);
    chk("bad63_locked", 64'(locked), 64'd0);
    idle(7);
    for (int i = 0; i < 63; i++) begin good(7'd40); idle(7); end
    chk("good63_locked", 64'(locked), 64'd0);
    good(7'd40);
    chk("good64_locked", 64'(locked), 64'd1);

    // Loss through 16 bad headers.
    for (int i = 0; i < 15; i++) bad(7'd40);
    chk("bad15_locked", 64'(locked), 64'd1);
    bad(7'd40);
    chk("bad16_relock", 64'(relock), 64'd1);
    chk("bad16_locked", 64'(locked), 64'd0);
    idle(1);
    chk("relock_pulse", 64'(relock), 64'd0);

    // Relock, then 15 bad per window over three windows keeps lock.
    for (int i = 0; i < 64; i++) good(7'd40);
    chk("relocked", 64'(locked), 64'd1);
    for (int k = 1; k <= 3 * 1024; k++) begin
      if (k % 1024 < 15) bad(7'd40);
      else good(7'd40);
    end
    chk("windows_locked", 64'(locked), 64'd1);

    // Pause buffer, then offset change while locked.
    step(1, 1, 6'd32, 7'd40, rand_buf());
    chk("pause_dv", 64'(data_dv), 64'd0);
    good(7'd41);
    chk("offchg_dv", 64'(data_dv), 64'd1);
    chk("offchg_locked", 64'(locked), 64'd0);
    chk("offchg_relock", 64'(relock), 64'd0);

    // Reset mid-state, then window wrap on a bad 1024th block.
    step(0, 1, 6'd1, 7'd40, rand_buf());
    chk("rst2_locked", 64'(locked), 64'd0);
    for (int i = 0; i < 64; i++) good(7'd40);
    chk("wrap_lock", 64'(locked), 64'd1);
    for (int i = 0; i < 1023; i++) good(7'd40);
    bad(7'd40);
    for (int i = 0; i < 14; i++) bad(7'd40);
    chk("wrap_bad15_relock", 64'(relock), 64'd0);
    chk("wrap_bad15_locked", 64'(locked), 64'd1);
    bad(7'd40);
    chk("wrap_relock", 64'(relock), 64'd1);
    chk("wrap_locked", 64'(locked), 64'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
